edge_event_arbiter: RTL and testbench
=====================================

Name: edge_event_arbiter

Overview:
- Watches N single-bit event lines and detects a configurable edge type on each line.
- Records each detected edge as a pending event per channel.
- Shares one downstream event channel (valid/ready) between all channels using round-robin arbitration.
- Sits between raw status/strobe lines and an event consumer such as an interrupt controller or CSR block.

Parameters:
- NUM_CH, 4, number of event channels; legal range 2..16.
- CH_W, $clog2(NUM_CH), width of the channel ID.
- TS_W, 16, timestamp width; used only with the optional feature.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  synchronous active-low reset.
- SAMPLE_IN  in  NUM_CH  raw event lines; already synchronous to CLK.
- EDGE_SEL  in  2*NUM_CH  per-channel mode: 00 disabled, 01 rise, 10 fall, 11 both.
- EVT_VALID  out  1  event offered.
- EVT_READY  in  1  consumer accepts.
- EVT_ID  out  CH_W  channel of the offered event.
- EVT_RISE  out  1  1 = rising edge, 0 = falling edge.
- PENDING  out  NUM_CH  pending flags.
- OVF  out  NUM_CH  sticky overflow flags.
- OVF_CLR  in  NUM_CH  write-1 clear mask for OVF.

Behaviour:
- Reset: follower stages, PENDING, OVF and the polarity store are 0. EVT_VALID, EVT_ID and EVT_RISE are 0. FSM is in IDLE. Round-robin pointer is NUM_CH-1, so channel 0 has first priority. Reset mid-handshake drops the offered event and all pending events.
- Detection, per channel: 2-bit follower, new sample into [0], old into [1], cleared by reset.
  - rise = (follower == 01); fall = (follower == 10).
  - hit = (rise & EDGE_SEL[2i]) | (fall & EDGE_SEL[2i+1]).
  - Because the follower resets to 00, a line already high at reset release produces one rise.
- Pending:
  - hit with pending clear: pending set at the next edge; polarity stored (1 = rise).
  - hit with pending already set (including the channel currently offered): pending and polarity unchanged; OVF[i] set.
  - hit in the same cycle the channel's offer is accepted: pending stays set with the new polarity; no overflow.
  - Changing EDGE_SEL to 00 suppresses new hits only. Existing pending events are still delivered.
- Overflow: OVF is sticky. OVF_CLR[i] clears bit i. A set and a clear of the same bit in the same cycle: set wins.
- FSM:
  - IDLE: if any PENDING, select the first set bit searching from pointer+1 upward with wrap. Register EVT_ID/EVT_RISE, assert EVT_VALID, go to OFFER.
  - OFFER: outputs held stable while EVT_READY = 0. On VALID & READY: clear that pending bit (subject to the new-hit rule above), set pointer = EVT_ID, deassert EVT_VALID, go to IDLE.
  - Minimum one idle cycle between offers, so peak throughput is 1 event per 2 cycles.
- Latency:
  - Line change sampled at edge k.
  - PENDING visible after edge k+1.
  - EVT_VALID high after edge k+2, when the FSM is idle.
- Fairness: a channel re-raising continuously waits until every other pending channel has been served once.

Optional Feature:
- Macro EDGE_EVENT_ARBITER_TIMESTAMP_EN.
- When defined:
  - free-running TS_W counter, reset 0, wraps at all-ones to 0;
  - per-channel TS register captures the counter value in the cycle the pending bit is set (not on overflow hits);
  - extra output EVT_TS (out, TS_W) is registered with EVT_ID and held during OFFER.
- When undefined: no counter, no TS registers and no EVT_TS port.

Decomposition:
- Package edge_event_arbiter_pkg:
  - edge_sel_t enum (SEL_OFF = 2'b00, SEL_RISE = 2'b01, SEL_FALL = 2'b10, SEL_BOTH = 2'b11);
  - fsm_t enum (ST_IDLE, ST_OFFER);
  - function rr_pick(pending, pointer) returning the next channel index.
- Sub-module: the existing edge detector block, instantiated NUM_CH times, provides the rise/fall strobes. No other sub-modules.

Test Plan:
- Reset release with SAMPLE_IN = 0, EDGE_SEL = 01 on all channels; channel 2 goes 0->1 at edge k, READY = 1 → EVT_VALID at k+2 with EVT_ID = 2, EVT_RISE = 1; PENDING[2] clears after the handshake.
- Rising edges on channels 0, 1 and 3 in the same cycle, READY = 1 → events delivered in order 0, 1, 3, each accepted at consecutive offers; re-raise channel 0 during this → served after 3.
- EDGE_SEL[1] = 10, channel 1 toggles 1->0, 0->1, 1->0 while READY = 0 → a single falling event is offered; OVF[1] = 1 after the second falling edge; OVF_CLR = 0010 clears it; concurrent clear and new overflow → OVF[1] stays 1.
- EVT_READY held 0 for 10 cycles → EVT_ID/EVT_RISE stable and EVT_VALID high for the whole window.
- Edge on the offered channel in the acceptance cycle → PENDING stays 1 with the new polarity, OVF unchanged, re-offered after one idle cycle.
- RSTN low during OFFER → next cycle EVT_VALID = 0, PENDING = 0, OVF = 0, pointer restored so channel 0 wins the next tie. With EDGE_EVENT_ARBITER_TIMESTAMP_EN defined, EVT_TS equals the counter value captured at pending-set.

Source files
------------

// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and the round-robin selection helper for edge_event_arbiter.
package edge_event_arbiter_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic [1:0] {
        SEL_OFF  = 2'b00,
        SEL_RISE = 2'b01,
        SEL_FALL = 2'b10,
        SEL_BOTH = 2'b11
    } edge_sel_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } fsm_t;

    // First set bit of pending, searching from pointer+1 upward and wrapping at num_ch.
    function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] pending,
                                           input logic [3:0]        pointer,
                                           input logic [4:0]        num_ch);
        logic [3:0] pick;
        logic       found;
        logic [4:0] idx;
        pick  = pointer;
        found = 1'b0;
        for (int k = 1; k <= MAX_CH; k++) begin
            idx = 5'(({1'b0, pointer} + 5'(k)) % num_ch);
            if (!found && (5'(k) <= num_ch) && pending[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_edge_det.sv
// Two-stage follower producing single-cycle rise/fall strobes for one event line.
module edge_event_arbiter_edge_det (
    input  logic CLK,
    input  logic RSTN,
    input  logic sample_i,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] fol_q;
    logic [1:0] fol_d;

    // Shift the new sample into bit 0, previous sample into bit 1
    always_comb begin
        fol_d = {fol_q[0], sample_i};
    end

    // Follower register; clears to 00 so a line high at reset release yields one rise
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            fol_q <= 2'b00;
        end else begin
            fol_q <= fol_d;
        end
    end

    assign rise_o = (fol_q == 2'b01);
    assign fall_o = (fol_q == 2'b10);

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge capture with round-robin sharing of one valid/ready event port.
// Optional event timestamps: define EDGE_EVENT_ARBITER_TIMESTAMP_EN.
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH),
    parameter int TS_W   = 16
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic [NUM_CH-1:0]   SAMPLE_IN,
    input  logic [2*NUM_CH-1:0] EDGE_SEL,
    output logic                EVT_VALID,
    input  logic                EVT_READY,
    output logic [CH_W-1:0]     EVT_ID,
    output logic                EVT_RISE,
    output logic [NUM_CH-1:0]   PENDING,
    output logic [NUM_CH-1:0]   OVF,
    input  logic [NUM_CH-1:0]   OVF_CLR
`ifdef EDGE_EVENT_ARBITER_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]     EVT_TS
`endif
);

    logic [NUM_CH-1:0] rise_s;
    logic [NUM_CH-1:0] fall_s;
    logic [NUM_CH-1:0] hit_s;
    logic [NUM_CH-1:0] set_s;
    logic [NUM_CH-1:0] ovf_set_s;
    logic              accept_s;
    logic [CH_W-1:0]   pick_s;

    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] pol_q, pol_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    fsm_t              state_q, state_d;
    logic              valid_q, valid_d;
    logic [CH_W-1:0]   id_q, id_d;
    logic              rise_q, rise_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_det
        edge_event_arbiter_edge_det u_det (
            .CLK      (CLK),
            .RSTN     (RSTN),
            .sample_i (SAMPLE_IN[g]),
            .rise_o   (rise_s[g]),
            .fall_o   (fall_s[g])
        );
    end

    // Qualify detector strobes with the per-channel edge mode
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (edge_sel_t'(EDGE_SEL[2*i +: 2]))
                SEL_RISE: hit_s[i] = rise_s[i];
                SEL_FALL: hit_s[i] = fall_s[i];
                SEL_BOTH: hit_s[i] = rise_s[i] | fall_s[i];
                default:  hit_s[i] = 1'b0;
            endcase
        end
    end

    assign accept_s = (state_q == ST_OFFER) && EVT_READY;

    // Pending/polarity/overflow update; a hit on the channel being accepted re-arms it
    always_comb begin
        pend_d    = pend_q;
        pol_d     = pol_q;
        set_s     = '0;
        ovf_set_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hit_s[i] && (!pend_q[i] || (accept_s && (id_q == CH_W'(i))))) begin
                pend_d[i] = 1'b1;
                pol_d[i]  = rise_s[i];
                set_s[i]  = 1'b1;
            end else if (hit_s[i]) begin
                ovf_set_s[i] = 1'b1;
            end else if (accept_s && (id_q == CH_W'(i))) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
        ovf_d = (ovf_q & ~OVF_CLR) | ovf_set_s;
    end

    assign pick_s = CH_W'(rr_pick(MAX_CH'(pend_q), 4'(ptr_q), 5'(NUM_CH)));

`ifdef EDGE_EVENT_ARBITER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] ts_q [NUM_CH];
    logic [TS_W-1:0] evt_ts_q, evt_ts_d;

    // Free-running counter and capture of its value when a channel goes pending
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            ts_cnt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ts_q[i] <= '0;
            end
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (set_s[i]) begin
                    ts_q[i] <= ts_cnt_q;
                end else begin
                    ts_q[i] <= ts_q[i];
                end
            end
        end
    end

    // Timestamp travels with the offered ID and is frozen during OFFER
    always_comb begin
        evt_ts_d = evt_ts_q;
        if ((state_q == ST_IDLE) && (|pend_q)) begin
            evt_ts_d = ts_q[pick_s];
        end else begin
            evt_ts_d = evt_ts_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            evt_ts_q <= '0;
        end else begin
            evt_ts_q <= evt_ts_d;
        end
    end

    assign EVT_TS = evt_ts_q;
`else
    logic unused_set_s;
    assign unused_set_s = ^set_s;
`endif

    // Offer FSM: one idle cycle between offers, outputs frozen while waiting for ready
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        rise_d  = rise_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    id_d    = pick_s;
                    rise_d  = pol_q[pick_s];
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end else begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (EVT_READY) begin
                    ptr_d   = id_q;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; pointer resets to the last channel so channel 0 wins first
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            pend_q  <= '0;
            pol_q   <= '0;
            ovf_q   <= '0;
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            rise_q  <= 1'b0;
            ptr_q   <= CH_W'(NUM_CH - 1);
        end else begin
            pend_q  <= pend_d;
            pol_q   <= pol_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            rise_q  <= rise_d;
            ptr_q   <= ptr_d;
        end
    end

    assign EVT_VALID = valid_q;
    assign EVT_ID    = id_q;
    assign EVT_RISE  = rise_q;
    assign PENDING   = pend_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (NUM_CH = 4); checks EVT_TS when
// EDGE_EVENT_ARBITER_TIMESTAMP_EN is defined.
module tb_edge_event_arbiter;

    logic       clk_s;
    logic       rstn_s;
    logic [3:0] sample_s;
    logic [7:0] edge_sel_s;
    logic       evt_valid_s;
    logic       evt_ready_s;
    logic [1:0] evt_id_s;
    logic       evt_rise_s;
    logic [3:0] pending_s;
    logic [3:0] ovf_s;
    logic [3:0] ovf_clr_s;
`ifdef EDGE_EVENT_ARBITER_TIMESTAMP_EN
    logic [15:0] evt_ts_s;
`endif

    int checks_r = 0;
    int errors_r = 0;

    edge_event_arbiter #(.NUM_CH(4)) dut (
        .CLK       (clk_s),
        .RSTN      (rstn_s),
        .SAMPLE_IN (sample_s),
        .EDGE_SEL  (edge_sel_s),
        .EVT_VALID (evt_valid_s),
        .EVT_READY (evt_ready_s),
        .EVT_ID    (evt_id_s),
        .EVT_RISE  (evt_rise_s),
        .PENDING   (pending_s),
        .OVF       (ovf_s),
        .OVF_CLR   (ovf_clr_s)
`ifdef EDGE_EVENT_ARBITER_TIMESTAMP_EN
        ,
        .EVT_TS    (evt_ts_s)
`endif
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_r++;
        if (act !== exp) begin
            errors_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic check_offer(input string tag, input logic [1:0] id, input logic rise);
        check({tag, "_valid"}, 32'(evt_valid_s), 32'd1);
        check({tag, "_id"},    32'(evt_id_s),    32'(id));
        check({tag, "_rise"},  32'(evt_rise_s),  32'(rise));
    endtask

    initial begin
        rstn_s      = 1'b0;
        sample_s    = 4'b0000;
        edge_sel_s  = 8'b0101_0101;
        evt_ready_s = 1'b0;
        ovf_clr_s   = 4'b0000;
        tick();
        tick();
        check("rst_valid", 32'(evt_valid_s), 32'd0);
        check("rst_id",    32'(evt_id_s),    32'd0);
        check("rst_rise",  32'(evt_rise_s),  32'd0);
        check("rst_pend",  32'(pending_s),   32'd0);
        check("rst_ovf",   32'(ovf_s),       32'd0);

        // Single rise on channel 2 with the consumer ready
        rstn_s      = 1'b1;
        evt_ready_s = 1'b1;
        tick();
        sample_s = 4'b0100;
        tick();
        check("t1_pend_k", 32'(pending_s), 32'd0);
        tick();
        check("t1_pend_k1", 32'(pending_s), 32'b0100);
        check("t1_valid_k1", 32'(evt_valid_s), 32'd0);
        tick();
        check_offer("t1_k2", 2'd2, 1'b1);
        tick();
        check("t1_pend_done", 32'(pending_s), 32'd0);
        check("t1_valid_done", 32'(evt_valid_s), 32'd0);

        // Fresh reset so the pointer starts at channel 3 again
        rstn_s   = 1'b0;
        sample_s = 4'b0000;
        tick();
        tick();
        rstn_s = 1'b1;
        tick();

        // Simultaneous rises on 0, 1, 3; channel 0 re-raises and waits behind 3
        sample_s = 4'b1011;
        tick();
        tick();
        check("t2_pend", 32'(pending_s), 32'b1011);
        sample_s[0] = 1'b0;
        tick();
        check_offer("t2_first", 2'd0, 1'b1);
        tick();
        check("t2_gap", 32'(evt_valid_s), 32'd0);
        sample_s[0] = 1'b1;
        tick();
        check_offer("t2_second", 2'd1, 1'b1);
        tick();
        check("t2_pend_mid", 32'(pending_s), 32'b1001);
        tick();
        check_offer("t2_third", 2'd3, 1'b1);
        tick();
        tick();
        check_offer("t2_fourth", 2'd0, 1'b1);
        tick();
        check("t2_pend_done", 32'(pending_s), 32'd0);

        // Channel 1 in fall mode, consumer stalled
        edge_sel_s[3:2] = 2'b10;
        evt_ready_s     = 1'b0;
        sample_s[1]     = 1'b0;
        tick();
        tick();
        check("t3_pend", 32'(pending_s), 32'b0010);
        sample_s[1] = 1'b1;
        tick();
        check_offer("t3_offer", 2'd1, 1'b0);
        tick();
        sample_s[1] = 1'b0;
        tick();
        check("t3_ovf_pre", 32'(ovf_s), 32'd0);
        tick();
        check("t3_ovf", 32'(ovf_s), 32'b0010);
        check("t3_pend_ovf", 32'(pending_s), 32'b0010);
        for (int n = 0; n < 10; n++) begin
            tick();
            check_offer("t4_stall", 2'd1, 1'b0);
        end
        ovf_clr_s = 4'b0010;
        tick();
        ovf_clr_s = 4'b0000;
        check("t3_ovf_clr", 32'(ovf_s), 32'd0);
        sample_s[1] = 1'b1;
        tick();
        tick();
        sample_s[1] = 1'b0;
        tick();
        ovf_clr_s = 4'b0010;
        tick();
        ovf_clr_s = 4'b0000;
        check("t3_set_wins", 32'(ovf_s), 32'b0010);
        ovf_clr_s = 4'b0010;
        tick();
        ovf_clr_s   = 4'b0000;
        evt_ready_s = 1'b1;
        tick();
        check("t3_pend_done", 32'(pending_s), 32'd0);
        check("t3_valid_done", 32'(evt_valid_s), 32'd0);
        tick();
        check("t3_no_reoffer", 32'(evt_valid_s), 32'd0);

        // Channel 0 in both-edge mode: new edge lands in its acceptance cycle
        edge_sel_s[1:0] = 2'b11;
        evt_ready_s     = 1'b0;
        sample_s[0]     = 1'b0;
        tick();
        tick();
        tick();
        check_offer("t5_fall", 2'd0, 1'b0);
        sample_s[0] = 1'b1;
        tick();
        check_offer("t5_hold", 2'd0, 1'b0);
        evt_ready_s = 1'b1;
        tick();
        evt_ready_s = 1'b0;
        check("t5_pend", 32'(pending_s), 32'b0001);
        check("t5_ovf", 32'(ovf_s), 32'd0);
        check("t5_gap", 32'(evt_valid_s), 32'd0);
        tick();
        check_offer("t5_reoffer", 2'd0, 1'b1);
        sample_s[0] = 1'b0;
        tick();
        tick();
        check("t6_ovf_pre", 32'(ovf_s), 32'b0001);

        // Reset during OFFER drops everything and restores the pointer
        rstn_s     = 1'b0;
        sample_s   = 4'b0000;
        edge_sel_s = 8'b0101_0101;
        tick();
        check("t6_valid", 32'(evt_valid_s), 32'd0);
        check("t6_pend",  32'(pending_s),   32'd0);
        check("t6_ovf",   32'(ovf_s),       32'd0);
        rstn_s   = 1'b1;
        sample_s = 4'b1001;
        tick();
        tick();
        check("t6_pend_tie", 32'(pending_s), 32'b1001);
        tick();
        check_offer("t6_tie", 2'd0, 1'b1);
`ifdef EDGE_EVENT_ARBITER_TIMESTAMP_EN
        check("t6_ts", 32'(evt_ts_s), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
